// File: rtl/result_acc_pkg.sv
// Shared types and constants for the frame result accumulator.
package result_acc_pkg;

    // Default widths: 9-bit signed samples, frames of up to 16 samples.
    localparam int DATA_W_DEF = 9;
    localparam int CNT_W_DEF  = 4;

    // Extreme sample values for the default sample width.
    localparam logic signed [DATA_W_DEF-1:0] SAMPLE_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic signed [DATA_W_DEF-1:0] SAMPLE_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : result_acc_pkg

// File: rtl/acc_datapath.sv
// Running sum / min / max / count registers for one frame.
// clr starts a fresh frame, en folds in one accepted sample.
module acc_datapath
    import result_acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           en,
    input  logic signed [DATA_W-1:0]       in_data,
    output logic signed [DATA_W+CNT_W-1:0] sum,
    output logic signed [DATA_W-1:0]       min_val,
    output logic signed [DATA_W-1:0]       max_val,
    output logic        [CNT_W:0]          count
);

    localparam int SUM_W = DATA_W + CNT_W;

    // Clear values: min starts at the top of the range, max at the bottom,
    // so the first sample always replaces both.
    localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic signed [DATA_W-1:0] min_q, min_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic        [CNT_W:0]    count_q, count_d;
    logic signed [SUM_W-1:0]  sample_ext;

    assign sample_ext = {{CNT_W{in_data[DATA_W-1]}}, in_data};

    // Next-state: clear takes precedence over accumulate; otherwise hold.
    always_comb begin
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        if (clr) begin
            sum_d   = '0;
            min_d   = D_MAX;
            max_d   = D_MIN;
            count_d = '0;
        end else if (en) begin
            sum_d   = sum_q + sample_ext;
            count_d = count_q + (CNT_W+1)'(1);
            if (in_data < min_q) min_d = in_data;
            if (in_data > max_q) max_d = in_data;
        end
    end

    // Registers; reset zeroes everything, including min and max.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
        end else begin
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
        end
    end

    assign sum     = sum_q;
    assign min_val = min_q;
    assign max_val = max_q;
    assign count   = count_q;

endmodule : acc_datapath

// File: rtl/result_accumulator.sv
// Frame statistics collector: accepts frame_len signed samples, then
// presents sum/min/max/count until the consumer acknowledges.
module result_accumulator
    import result_acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic        [CNT_W-1:0]        frame_len,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_W-1:0]       in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DATA_W+CNT_W-1:0] sum,
    output logic signed [DATA_W-1:0]       min_val,
    output logic signed [DATA_W-1:0]       max_val,
    output logic        [CNT_W:0]          count,
    output logic                           busy
);

    state_t           state_q, state_d;
    logic [CNT_W:0]   len_q, len_d;
    logic             dp_clr;
    logic             xfer;
    logic             last_xfer;

    // A zero length field encodes the maximum frame of 2**CNT_W samples.
    logic [CNT_W:0]   len_decoded;
    assign len_decoded = (frame_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, frame_len};

    assign xfer      = in_valid && (state_q == ST_ACCUM);
    assign last_xfer = xfer && ((count + (CNT_W+1)'(1)) == len_q);

    // Next-state and outputs; start only counts in IDLE, so a start that
    // coincides with the DONE handshake is dropped.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        dp_clr    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_ACCUM;
                    len_d   = len_decoded;
                    dp_clr  = 1'b1;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (last_xfer) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched frame length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    acc_datapath #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .clr     (dp_clr),
        .en      (xfer),
        .in_data (in_data),
        .sum     (sum),
        .min_val (min_val),
        .max_val (max_val),
        .count   (count)
    );

endmodule : result_accumulator

// File: tb/tb_result_accumulator.sv
// Directed bench for result_accumulator with default widths (9/4).
module tb_result_accumulator;
    import result_acc_pkg::*;

    localparam int DW = 9;
    localparam int CW = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     start = 1'b0;
    logic        [CW-1:0]     frame_len = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DW-1:0]     in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [DW+CW-1:0]  sum;
    logic signed [DW-1:0]     min_val;
    logic signed [DW-1:0]     max_val;
    logic        [CW:0]       count;
    logic                     busy;

    int total = 0;
    int bad   = 0;

    result_accumulator #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .min_val   (min_val),
        .max_val   (max_val),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [CW-1:0] len);
        start = 1'b1;
        frame_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic send_sample(input int d);
        in_valid = 1'b1;
        in_data = DW'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        frame_len = 4'd2;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0d want 0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %0d want 0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %0d want 0", out_valid); end
        total++; if (sum !== 0) begin bad++; $display("FAIL reset_sum got %0d want 0", sum); end
        total++; if (count !== 0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
        total++; if (min_val !== 0 || max_val !== 0) begin bad++; $display("FAIL reset_minmax got %0d/%0d want 0/0", min_val, max_val); end
        $display("reset: busy=%0d sum=%0d count=%0d", busy, sum, count);
    endtask

    task automatic test_basic();
        start_frame(4'd4);
        total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL basic_accum_entry got ready=%0d busy=%0d want 1/1", in_ready, busy); end
        send_sample(25);
        total++; if (sum !== 25 || count !== 1) begin bad++; $display("FAIL basic_first got sum=%0d count=%0d want 25/1", sum, count); end
        send_sample(-30);
        send_sample(7);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got %0d want 0", out_valid); end
        out_ready = 1'b1;
        send_sample(-1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got %0d want 1", out_valid); end
        total++; if (sum !== 1) begin bad++; $display("FAIL basic_sum got %0d want 1", sum); end
        total++; if (min_val !== -30 || max_val !== 25) begin bad++; $display("FAIL basic_minmax got %0d/%0d want -30/25", min_val, max_val); end
        total++; if (count !== 4 || in_ready !== 1'b0) begin bad++; $display("FAIL basic_count got count=%0d ready=%0d want 4/0", count, in_ready); end
        $display("frame basic: sum=%0d min=%0d max=%0d count=%0d", sum, min_val, max_val, count);
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_to_idle got valid=%0d busy=%0d want 0/0", out_valid, busy); end
        total++; if (sum !== 1 || count !== 4) begin bad++; $display("FAIL basic_idle_hold got sum=%0d count=%0d want 1/4", sum, count); end
    endtask

    task automatic test_full_len();
        start_frame(4'd0);
        for (int i = 0; i < 16; i++) send_sample(int'(SAMPLE_MAX));
        total++; if (out_valid !== 1'b1 || sum !== 4080) begin bad++; $display("FAIL full_pos_sum got valid=%0d sum=%0d want 1/4080", out_valid, sum); end
        total++; if (min_val !== 255 || max_val !== 255 || count !== 16) begin bad++; $display("FAIL full_pos_stats got %0d/%0d/%0d want 255/255/16", min_val, max_val, count); end
        $display("frame full+: sum=%0d count=%0d", sum, count);
        handshake();
        start_frame(4'd0);
        for (int i = 0; i < 16; i++) send_sample(int'(SAMPLE_MIN));
        total++; if (out_valid !== 1'b1 || sum !== -4096) begin bad++; $display("FAIL full_neg_sum got valid=%0d sum=%0d want 1/-4096", out_valid, sum); end
        total++; if (min_val !== -256 || max_val !== -256 || count !== 16) begin bad++; $display("FAIL full_neg_stats got %0d/%0d/%0d want -256/-256/16", min_val, max_val, count); end
        $display("frame full-: sum=%0d count=%0d", sum, count);
        handshake();
    endtask

    task automatic test_gaps();
        start_frame(4'd3);
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            in_data = DW'(10 + i);
            tick();
            total++;
            if (out_valid !== (i >= 4)) begin bad++; $display("FAIL gaps_valid_%0d got %0d want %0d", i, out_valid, (i >= 4)); end
        end
        in_valid = 1'b0;
        total++; if (count !== 3 || sum !== 36) begin bad++; $display("FAIL gaps_result got count=%0d sum=%0d want 3/36", count, sum); end
        total++; if (min_val !== 10 || max_val !== 14) begin bad++; $display("FAIL gaps_minmax got %0d/%0d want 10/14", min_val, max_val); end
        $display("frame gaps: sum=%0d count=%0d", sum, count);
        handshake();
    endtask

    task automatic test_hold();
        start_frame(4'd2);
        send_sample(5);
        send_sample(-3);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 9'sd100;
            tick();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 2 || min_val !== -3 || max_val !== 5 || count !== 2) begin
                bad++;
                $display("FAIL hold_cycle_%0d got v=%0d r=%0d sum=%0d min=%0d max=%0d cnt=%0d want 1/0/2/-3/5/2",
                         i, out_valid, in_ready, sum, min_val, max_val, count);
            end
        end
        in_valid = 1'b0;
        $display("frame hold: sum=%0d count=%0d", sum, count);
        handshake();
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hold_release got valid=%0d busy=%0d want 0/0", out_valid, busy); end
    endtask

    task automatic test_abort();
        start_frame(4'd4);
        send_sample(40);
        send_sample(-8);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 9'sd7;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        total++; if (sum !== 0 || count !== 0 || min_val !== 0 || max_val !== 0) begin bad++; $display("FAIL abort_zero got sum=%0d cnt=%0d min=%0d max=%0d want 0", sum, count, min_val, max_val); end
        total++; if (busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL abort_idle got busy=%0d ready=%0d want 0/0", busy, in_ready); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            tick();
            total++;
            if (out_valid !== 1'b0 || count !== 0) begin bad++; $display("FAIL abort_quiet_%0d got valid=%0d count=%0d want 0/0", i, out_valid, count); end
        end
        in_valid = 1'b0;
        $display("abort: frame dropped, count=%0d", count);
        start_frame(4'd4);
        send_sample(1);
        send_sample(2);
        send_sample(3);
        send_sample(4);
        total++; if (out_valid !== 1'b1 || sum !== 10 || min_val !== 1 || max_val !== 4 || count !== 4) begin
            bad++;
            $display("FAIL abort_fresh got v=%0d sum=%0d min=%0d max=%0d cnt=%0d want 1/10/1/4/4", out_valid, sum, min_val, max_val, count);
        end
        $display("frame fresh: sum=%0d count=%0d", sum, count);
        handshake();
    endtask

    task automatic test_start_ignored();
        start_frame(4'd3);
        send_sample(1);
        start = 1'b1;
        frame_len = 4'd1;
        send_sample(2);
        start = 1'b0;
        total++; if (out_valid !== 1'b0 || count !== 2 || sum !== 3) begin bad++; $display("FAIL ign_accum got v=%0d cnt=%0d sum=%0d want 0/2/3", out_valid, count, sum); end
        send_sample(3);
        total++; if (out_valid !== 1'b1 || count !== 3 || sum !== 6) begin bad++; $display("FAIL ign_done got v=%0d cnt=%0d sum=%0d want 1/3/6", out_valid, count, sum); end
        start = 1'b1;
        frame_len = 4'd2;
        tick();
        total++; if (out_valid !== 1'b1 || count !== 3) begin bad++; $display("FAIL ign_in_done got v=%0d cnt=%0d want 1/3", out_valid, count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL ign_handshake got busy=%0d v=%0d want 0/0", busy, out_valid); end
        in_valid = 1'b1;
        in_data = 9'sd50;
        tick();
        tick();
        in_valid = 1'b0;
        total++; if (busy !== 1'b0 || in_ready !== 1'b0 || count !== 3 || sum !== 6) begin
            bad++;
            $display("FAIL ign_idle_stay got busy=%0d ready=%0d cnt=%0d sum=%0d want 0/0/3/6", busy, in_ready, count, sum);
        end
        $display("frame start-ignore: sum=%0d count=%0d", sum, count);
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_full_len();
        test_gaps();
        test_hold();
        test_abort();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_result_accumulator

// File: doc/result_accumulator.md
RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

Interface
REQ-001 Parameter DATA_W, default 9, SHALL set the width of the signed result word from the upstream math stage.
REQ-002 Parameter CNT_W, default 4, SHALL set the width of the frame-length field; maximum frame length is 2**CNT_W.
REQ-003 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 start  in  1  SHALL be a one-cycle request to begin a frame; it is honoured only in IDLE.
REQ-006 frame_len  in  CNT_W  SHALL give the number of samples per frame; it is sampled when start is honoured; value 0 means 2**CNT_W.
REQ-007 in_valid  in  1  SHALL indicate that in_data holds a result.
REQ-008 in_ready  out  1  SHALL indicate that the block accepts a sample this cycle.
REQ-009 in_data  in  DATA_W signed  SHALL carry the upstream result word.
REQ-010 out_valid  out  1  SHALL indicate that the frame statistics are valid.
REQ-011 out_ready  in  1  SHALL indicate that the consumer takes the statistics.
REQ-012 sum  out  DATA_W+CNT_W signed  SHALL carry the frame sum.
REQ-013 min_val, max_val  out  DATA_W signed  SHALL carry the frame minimum and maximum.
REQ-014 count  out  CNT_W+1  SHALL carry the number of samples accepted in the current or last frame.
REQ-015 busy  out  1  SHALL be high in every state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-017 IDLE->ACCUM on start: latch frame_len, clear sum and count, set min_val to the most-positive value and max_val to the most-negative value.
REQ-018 in_ready SHALL equal 1 only in ACCUM; a transfer occurs when in_valid and in_ready are both high.
REQ-019 On each transfer: sum += sign-extended in_data; count += 1; min_val and max_val update by signed compare; all results are visible the next cycle.
REQ-020 ACCUM->DONE on the transfer that makes count equal the latched length; out_valid SHALL rise the cycle after that transfer.
REQ-021 sum SHALL never overflow; DATA_W+CNT_W bits cover 2**CNT_W extreme samples, so no saturation logic is needed.
REQ-022 In DONE, out_valid=1 and sum, min_val, max_val and count SHALL hold stable until out_ready=1; that cycle returns the FSM to IDLE, with out_valid low next cycle.
REQ-023 Outputs SHALL keep their last frame values in IDLE until the next start.
REQ-024 start SHALL be ignored in ACCUM and DONE.
REQ-025 start asserted in the same cycle as the DONE->IDLE handshake SHALL be ignored; a new start is needed in IDLE.
REQ-026 in_valid while not in ACCUM SHALL be ignored and SHALL NOT alter state.
REQ-027 If in_valid stays low in ACCUM, the FSM SHALL wait indefinitely with no timeout.

Reset
REQ-028 rst SHALL force IDLE and set in_ready=0, out_valid=0, busy=0, sum=0, count=0, min_val=0, max_val=0 on the next edge.
REQ-029 rst during ACCUM or DONE SHALL abandon the frame; no out_valid is produced for it.
REQ-030 rst SHALL take priority over start, transfers and out_ready in the same cycle.

Structure
REQ-031 Package result_acc_pkg SHALL hold the state enum, the DATA_W and CNT_W defaults, and the MIN and MAX constants derived from DATA_W.
REQ-032 One sub-module, acc_datapath, SHALL hold the sum, min, max and count registers, with clear and enable inputs driven by the FSM.

Verification
REQ-033 frame_len=4 with samples 25, -30, 7, -1 and out_ready high -> out_valid one cycle after the 4th transfer; sum=1, min=-30, max=25, count=4.
REQ-034 frame_len=0 with 16 samples of 255 -> sum=4080, min=max=255, count=16; then 16 samples of -256 -> sum=-4096.
REQ-035 frame_len=3 with in_valid toggled every other cycle -> exactly 3 transfers, and DONE is entered only after the 3rd.
REQ-036 In DONE, out_ready held low for 5 cycles -> outputs stable and in_ready=0; out_ready=1 -> IDLE the next cycle.
REQ-037 rst pulsed after 2 of 4 samples -> all outputs 0 and no out_valid; a new start then gives a correct fresh frame.
REQ-038 start asserted during ACCUM and in the DONE handshake cycle -> no effect on the frame; FSM stays in IDLE after the handshake.
